itoa3: RTL and testbench

- Converts an 8-bit unsigned binary value (0..255) into three ASCII decimal digit characters; it is the inverse of the 3-character ASCII-to-number converter in the STR string path.
- Feeds the text/report output path, so parsed numeric fields can be written back as 3-character ASCII.
- Conversion is sequential double-dabble (shift-add-3) over 8 iterations, with a start/busy/done handshake.

---
 rtl/itoa3_pkg.sv | 20 ++
 rtl/itoa3_if.sv | 22 ++
 rtl/itoa3_dabble_step.sv | 22 ++
 rtl/itoa3.sv | 130 +++++++++++++
 tb/tb_itoa3.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/itoa3_pkg.sv
// Shared STR definitions: ASCII constants, FSM encoding and the iteration
// count for the 8-bit double-dabble converter.
package itoa3_pkg;

  localparam logic [7:0] ASCII_ZERO   = 8'h30;
  localparam logic [7:0] ASCII_SPACE  = 8'h20;
  localparam int         DABBLE_ITERS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FORMAT = 2'd2
  } state_t;

  // ASCII character for one BCD digit (digit is at most 9, so no overflow)
  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/itoa3_if.sv
// Request/result bundle of the number-to-ASCII converter.
// The master issues start/NUM; the slave (converter) returns the status and characters.
interface itoa3_if;
  logic       start;
  logic [7:0] NUM;
  logic       busy;
  logic       done;
  logic [7:0] CHAR0;
  logic [7:0] CHAR1;
  logic [7:0] CHAR2;
  logic [1:0] NDIG;

  modport master (
    output start, NUM,
    input  busy, done, CHAR0, CHAR1, CHAR2, NDIG
  );

  modport slave (
    input  start, NUM,
    output busy, done, CHAR0, CHAR1, CHAR2, NDIG
  );
endinterface

// File: rtl/itoa3_dabble_step.sv
// One combinational double-dabble step: add 3 to every BCD nibble >= 5,
// then shift the {bcd, bin} pair left by one bit.
module itoa3_dabble_step (
  input  logic [11:0] bcd_in,
  input  logic [7:0]  bin_in,
  output logic [11:0] bcd_out,
  output logic [7:0]  bin_out
);

  logic [11:0] bcd_adj;

  // Per-nibble add-3 correction so the following shift carries correctly in decimal
  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_nibble
    assign bcd_adj[gi*4 +: 4] = (bcd_in[gi*4 +: 4] >= 4'd5) ? bcd_in[gi*4 +: 4] + 4'd3
                                                             : bcd_in[gi*4 +: 4];
  end

  // Shift the corrected BCD and the remaining binary bits as one 20-bit word
  assign {bcd_out, bin_out} = {bcd_adj, bin_in} << 1;

endmodule

// File: rtl/itoa3.sv
// 8-bit unsigned binary to three ASCII decimal characters.
// Sequential double-dabble: accept, 8 shift steps, then one formatting step.
module itoa3
  import itoa3_pkg::*;
#(
  parameter logic [7:0] PAD_CHAR = ASCII_ZERO
) (
  input  logic    clk,
  input  logic    reset,
  itoa3_if.slave  bus
);

  state_t      state_reg, state_next;
  logic [7:0]  bin_reg, bin_next;
  logic [11:0] bcd_reg, bcd_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic [7:0]  char0_reg, char0_next;
  logic [7:0]  char1_reg, char1_next;
  logic [7:0]  char2_reg, char2_next;
  logic [1:0]  ndig_reg, ndig_next;

  logic [11:0] step_bcd;
  logic [7:0]  step_bin;
  logic [3:0]  hundreds, tens, ones;

  // Single step instance, iterated over the counter while in SHIFT
  itoa3_dabble_step u_step (
    .bcd_in  (bcd_reg),
    .bin_in  (bin_reg),
    .bcd_out (step_bcd),
    .bin_out (step_bin)
  );

  assign hundreds = bcd_reg[11:8];
  assign tens     = bcd_reg[7:4];
  assign ones     = bcd_reg[3:0];

  // State and datapath registers; reset loads the formatted image of zero
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      bin_reg   <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      char0_reg <= PAD_CHAR;
      char1_reg <= PAD_CHAR;
      char2_reg <= ASCII_ZERO;
      ndig_reg  <= 2'd1;
    end else begin
      state_reg <= state_next;
      bin_reg   <= bin_next;
      bcd_reg   <= bcd_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      char0_reg <= char0_next;
      char1_reg <= char1_next;
      char2_reg <= char2_next;
      ndig_reg  <= ndig_next;
    end
  end

  // Next-state and datapath logic; outputs hold unless FORMAT rewrites them
  always_comb begin
    state_next = state_reg;
    bin_next   = bin_reg;
    bcd_next   = bcd_reg;
    cnt_next   = cnt_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    char0_next = char0_reg;
    char1_next = char1_reg;
    char2_next = char2_reg;
    ndig_next  = ndig_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          bin_next   = bus.NUM;
          bcd_next   = '0;
          cnt_next   = '0;
          busy_next  = 1'b1;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        bcd_next = step_bcd;
        bin_next = step_bin;
        cnt_next = cnt_reg + 3'd1;
        if (cnt_reg == 3'(DABBLE_ITERS - 1)) begin
          state_next = FORMAT;
        end
      end

      FORMAT: begin
        char2_next = digit_char(ones);
        char1_next = (hundreds == 4'd0 && tens == 4'd0) ? PAD_CHAR : digit_char(tens);
        char0_next = (hundreds == 4'd0) ? PAD_CHAR : digit_char(hundreds);
        if (hundreds != 4'd0) begin
          ndig_next = 2'd3;
        end else if (tens != 4'd0) begin
          ndig_next = 2'd2;
        end else begin
          ndig_next = 2'd1;
        end
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;
  assign bus.CHAR0 = char0_reg;
  assign bus.CHAR1 = char1_reg;
  assign bus.CHAR2 = char2_reg;
  assign bus.NDIG  = ndig_reg;

endmodule

// File: tb/tb_itoa3.sv
// Directed bench for itoa3: two instances share stimulus, one padding with
// '0' and one with ' ', and both are checked against hand-computed strings.
module tb_itoa3;
  import itoa3_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] num;

  int n_cmp     = 0;
  int n_bad     = 0;
  int cyc       = 0;
  int last_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  itoa3_if if_z ();
  itoa3_if if_s ();

  assign if_z.start = start;
  assign if_z.NUM   = num;
  assign if_s.start = start;
  assign if_s.NUM   = num;

  itoa3 #(.PAD_CHAR(ASCII_ZERO)) dut_z (
    .clk   (clk),
    .reset (reset),
    .bus   (if_z.slave)
  );

  itoa3 #(.PAD_CHAR(ASCII_SPACE)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (if_s.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Check both instances against the formatted image of zero
  task automatic chk_reset_image(input string tag);
    chk({tag, "_busy"},  {31'd0, if_z.busy | if_s.busy}, 32'd0);
    chk({tag, "_done"},  {31'd0, if_z.done | if_s.done}, 32'd0);
    chk({tag, "_chr_z"}, {8'd0, if_z.CHAR0, if_z.CHAR1, if_z.CHAR2}, 32'h00303030);
    chk({tag, "_chr_s"}, {8'd0, if_s.CHAR0, if_s.CHAR1, if_s.CHAR2}, 32'h00202030);
    chk({tag, "_ndig"},  {28'd0, if_z.NDIG, if_s.NDIG}, 32'h5);
  endtask

  // Start a conversion now (caller is 1 time unit past an edge), wait for done,
  // and leave the bench in the done cycle so the next call runs back-to-back.
  task automatic convert(input logic [7:0] v, input logic [23:0] exp_z,
                         input logic [23:0] exp_s, input logic [1:0] exp_nd,
                         input bit inject);
    int n;
    start = 1'b1;
    num   = v;
    @(posedge clk); #1;
    start = 1'b0;
    num   = 8'hA5;
    chk($sformatf("busy_after_accept_%0d", v), {31'd0, if_z.busy}, 32'd1);
    n = 0;
    while (!if_z.done && n < 20) begin
      if (inject && n == 2) begin
        start = 1'b1;
        num   = 8'd99;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk($sformatf("latency_%0d", v), n, 32'd9);
    chk($sformatf("done_z_%0d", v), {31'd0, if_z.done}, 32'd1);
    chk($sformatf("done_s_%0d", v), {31'd0, if_s.done}, 32'd1);
    chk($sformatf("busy_in_done_%0d", v), {31'd0, if_z.busy}, 32'd0);
    chk($sformatf("chars_z_%0d", v), {8'd0, if_z.CHAR0, if_z.CHAR1, if_z.CHAR2}, {8'd0, exp_z});
    chk($sformatf("chars_s_%0d", v), {8'd0, if_s.CHAR0, if_s.CHAR1, if_s.CHAR2}, {8'd0, exp_s});
    chk($sformatf("ndig_z_%0d", v), {30'd0, if_z.NDIG}, {30'd0, exp_nd});
    chk($sformatf("ndig_s_%0d", v), {30'd0, if_s.NDIG}, {30'd0, exp_nd});
    last_done = cyc;
    $display("convert %0d: z=\"%s%s%s\" s=\"%s%s%s\" ndig=%0d latency=%0d", v,
             if_z.CHAR0, if_z.CHAR1, if_z.CHAR2, if_s.CHAR0, if_s.CHAR1, if_s.CHAR2,
             if_z.NDIG, n);
  endtask

  initial begin
    int prev;
    int pulses;

    // Reset state
    reset = 1'b1;
    start = 1'b0;
    num   = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_image("reset");
    $display("reset: outputs at image of 0");
    reset = 1'b0;
    @(posedge clk); #1;

    // Largest value and zero
    convert(8'd255, 24'h323535, 24'h323535, 2'd3, 1'b0);
    @(posedge clk); #1;
    chk("done_one_cycle_255", {31'd0, if_z.done}, 32'd0);
    convert(8'd0, 24'h303030, 24'h202030, 2'd1, 1'b0);
    @(posedge clk); #1;

    // Back-to-back conversions started in each done cycle
    convert(8'd7, 24'h303037, 24'h202037, 2'd1, 1'b0);
    prev = last_done;
    convert(8'd100, 24'h313030, 24'h313030, 2'd3, 1'b0);
    chk("spacing_7_100", last_done - prev, 32'd10);
    prev = last_done;
    convert(8'd105, 24'h313035, 24'h313035, 2'd3, 1'b0);
    chk("spacing_100_105", last_done - prev, 32'd10);
    @(posedge clk); #1;
    chk("done_one_cycle_105", {31'd0, if_z.done}, 32'd0);

    // Start during busy is ignored: single result for 42, no second pulse
    repeat (2) @(posedge clk);
    #1;
    convert(8'd42, 24'h303432, 24'h203432, 2'd2, 1'b1);
    pulses = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (if_z.done || if_s.done) pulses++;
    end
    chk("single_done_42", pulses, 32'd0);
    $display("ignored start during busy: extra done pulses=%0d", pulses);

    // Reset sampled at the 4th SHIFT edge abandons the conversion
    start = 1'b1;
    num   = 8'd200;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_reset_image("midreset");
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (if_z.done || if_s.done || if_z.busy) pulses++;
    end
    chk("midreset_quiet", pulses, 32'd0);
    $display("reset mid-conversion of 200: activity afterwards=%0d", pulses);
    convert(8'd18, 24'h303138, 24'h203138, 2'd2, 1'b0);
    @(posedge clk); #1;

    // Reset and start together: reset wins
    reset = 1'b1;
    start = 1'b1;
    num   = 8'd55;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    chk_reset_image("reset_start");
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (if_z.done || if_s.done || if_z.busy || if_s.busy) pulses++;
    end
    chk("reset_start_quiet", pulses, 32'd0);
    $display("reset with start: activity afterwards=%0d", pulses);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
